// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state encoding, matrix geometry and the row/column helper functions.
package keypad_pkg;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int CODE_W = 4;

    localparam logic [ROWS-1:0] ROW_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } col_hit_t;

    // Lowest-index active column wins when several are low at once.
    function automatic col_hit_t col_encode(input logic [COLS-1:0] low);
        col_hit_t res;
        res = '{hit: 1'b0, idx: 2'd0};
        for (int i = COLS - 1; i >= 0; i--) begin
            if (low[i]) begin
                res.hit = 1'b1;
                res.idx = 2'(i);
            end
        end
        return res;
    endfunction

    function automatic logic [ROWS-1:0] row_drive(input logic [1:0] r);
        return ROW_IDLE ^ (ROWS'(1) << r);
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Key event bus from the keypad scanner to the game controller.
// The scanner drives it through the master modport; the controller listens on slave.
interface keypad_if
    import keypad_pkg::*;
();

    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_held;

    modport master (
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        input key_code,
        input key_valid,
        input key_held
    );

endinterface

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser bringing the asynchronous column sense lines into clk.
// Resets to all-high, which reads as "no key pressed".
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col_n,
    output logic [COLS-1:0] col_s
);

    logic [COLS-1:0] col_meta;

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value, which is what makes the two stages a real pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta <= '1;
            col_s    <= '1;
        end else begin
            col_meta <= col_n;
            col_s    <= col_meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row drive, column sampling, press/release debounce, key-code output.
// Optional auto-repeat while a key stays held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SETTLE_TICKS   = 2,
    parameter int DEBOUNCE_TICKS = 1000,
    parameter int REPEAT_TICKS   = 250
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_50k,
    input  logic [COLS-1:0] col_n,
    output logic [ROWS-1:0] row_n,
    keypad_if.master        key_bus
);

    localparam int SET_W = $clog2(SETTLE_TICKS + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_TICKS - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_TICKS);

    if (SETTLE_TICKS < 1 || DEBOUNCE_TICKS < 2 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("keypad_scan: SETTLE_TICKS>=1, DEBOUNCE_TICKS>=2, REPEAT_TICKS>=1 required");
    end

    // ------------------------------------------------------------------
    // Scan-rate tick and synchronised column sense
    // ------------------------------------------------------------------
    logic            clk_50k_d;
    logic            tick;
    logic [COLS-1:0] col_s;
    logic [COLS-1:0] sample;
    col_hit_t        enc;

    keypad_col_sync u_col_sync (
        .clk   (clk),
        .rst   (rst),
        .col_n (col_n),
        .col_s (col_s)
    );

    assign tick   = clk_50k & ~clk_50k_d;
    assign sample = ~col_s;
    assign enc    = col_encode(sample);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e            state,      state_nxt;
    logic [1:0]        row,        row_nxt;
    logic [1:0]        col_lat,    col_lat_nxt;
    logic [SET_W-1:0]  settle_cnt, settle_nxt;
    logic [DEB_W-1:0]  deb_cnt,    deb_nxt;
    logic [DEB_W-1:0]  rel_cnt,    rel_nxt;
    logic [CODE_W-1:0] code_q,     code_nxt;
    logic              valid_q,    valid_nxt;
    logic              held_q,     held_nxt;

`ifdef KEYPAD_REPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

    logic [REP_W-1:0] rep_cnt, rep_nxt;
`endif

    // ------------------------------------------------------------------
    // Next-state logic; everything except the key_valid pulse moves on tick only
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default before any branch so no
    // path leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        col_lat_nxt = col_lat;
        settle_nxt  = settle_cnt;
        deb_nxt     = deb_cnt;
        rel_nxt     = rel_cnt;
        code_nxt    = code_q;
        valid_nxt   = 1'b0;
        held_nxt    = held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_nxt     = rep_cnt;
`endif

        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (settle_cnt >= SET_LAST) begin
                        settle_nxt = '0;
                        if (enc.hit) begin
                            col_lat_nxt = enc.idx;
                            deb_nxt     = DEB_W'(1);
                            state_nxt   = DEBOUNCE;
                        end else begin
                            row_nxt = row + 2'd1;
                        end
                    end else begin
                        settle_nxt = settle_cnt + SET_W'(1);
                    end
                end

                DEBOUNCE: begin
                    if (enc.hit && enc.idx == col_lat) begin
                        deb_nxt = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + DEB_W'(1);
                        if (deb_cnt >= DEB_LAST) begin
                            code_nxt  = {row, col_lat};
                            valid_nxt = 1'b1;
                            held_nxt  = 1'b1;
                            deb_nxt   = '0;
                            rel_nxt   = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_nxt   = '0;
`endif
                            state_nxt = HELD;
                        end
                    end else begin
                        // A bounce sends us back to re-settle the same row.
                        deb_nxt    = '0;
                        settle_nxt = '0;
                        state_nxt  = SCAN;
                    end
                end

                HELD: begin
                    if (!sample[col_lat]) begin
                        rel_nxt = (rel_cnt == DEB_MAX) ? rel_cnt : rel_cnt + DEB_W'(1);
`ifdef KEYPAD_REPEAT_EN
                        rep_nxt = '0;
`endif
                        if (rel_cnt >= DEB_LAST) begin
                            held_nxt   = 1'b0;
                            rel_nxt    = '0;
                            settle_nxt = '0;
                            row_nxt    = row + 2'd1;
                            state_nxt  = SCAN;
                        end
                    end else begin
                        rel_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (rep_cnt >= REP_LAST) begin
                            rep_nxt   = '0;
                            valid_nxt = 1'b1;
                        end else begin
                            rep_nxt = rep_cnt + REP_W'(1);
                        end
`endif
                    end
                end

                default: state_nxt = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_50k_d  <= 1'b0;
            state      <= SCAN;
            row        <= '0;
            col_lat    <= '0;
            settle_cnt <= '0;
            deb_cnt    <= '0;
            rel_cnt    <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt    <= '0;
`endif
        end else begin
            clk_50k_d  <= clk_50k;
            state      <= state_nxt;
            row        <= row_nxt;
            col_lat    <= col_lat_nxt;
            settle_cnt <= settle_nxt;
            deb_cnt    <= deb_nxt;
            rel_cnt    <= rel_nxt;
            code_q     <= code_nxt;
            valid_q    <= valid_nxt;
            held_q     <= held_nxt;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt    <= rep_nxt;
`endif
        end
    end

    // Only the current row is pulled low; the row register is already reset to 0.
    assign row_n = row_drive(row);

    assign key_bus.key_code  = code_q;
    assign key_bus.key_valid = valid_q;
    assign key_bus.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key matrix.
// Expected pulse counts follow KEYPAD_REPEAT_EN when the bench is built with it.
module tb_keypad_scan;
    import keypad_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clk_50k;
    logic [COLS-1:0] col_n;
    logic [ROWS-1:0] row_n;
    logic [15:0]     pressed = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int p0;

    keypad_if key_bus ();

    keypad_scan #(
        .SETTLE_TICKS   (2),
        .DEBOUNCE_TICKS (4),
        .REPEAT_TICKS   (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_50k (clk_50k),
        .col_n   (col_n),
        .row_n   (row_n),
        .key_bus (key_bus)
    );

    always #5 clk = ~clk;

    // Scan clock: one rising edge every 200 clk, changed away from the active edge.
    initial begin
        clk_50k = 1'b0;
        forever begin
            repeat (100) @(negedge clk);
            clk_50k = ~clk_50k;
        end
    end

    // Key matrix: a pressed key shorts its column low while its row is driven low.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    always @(posedge clk) if (key_bus.key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n scan ticks; returns just after the clk edge that consumed the last one.
    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk_50k);
            @(posedge clk);
            #1;
        end
    endtask

    // One-clk reset, placed while clk_50k is low so no stray tick follows it.
    task automatic do_reset();
        @(negedge clk_50k);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // 1. Idle scan after reset
        do_reset();
        check("rst_row_n", 32'(row_n), 32'hE);
        check("rst_code", 32'(key_bus.key_code), 32'h0);
        check("rst_valid", 32'(key_bus.key_valid), 32'h0);
        check("rst_held", 32'(key_bus.key_held), 32'h0);
        tick_n(1); check("scan_t1", 32'(row_n), 32'hE);
        tick_n(1); check("scan_t2", 32'(row_n), 32'hD);
        tick_n(2); check("scan_t4", 32'(row_n), 32'hB);
        tick_n(2); check("scan_t6", 32'(row_n), 32'h7);
        tick_n(2); check("scan_wrap", 32'(row_n), 32'hE);
        check("scan_no_pulse", 32'(pulse_cnt), 32'h0);

        // 2. Clean press of row2/col1
        do_reset();
        p0 = pulse_cnt;
        pressed[9] = 1'b1;
        tick_n(8);
        check("t2_pre_valid", 32'(key_bus.key_valid), 32'h0);
        check("t2_deb_row", 32'(row_n), 32'hB);
        tick_n(1);
        check("t2_valid", 32'(key_bus.key_valid), 32'h1);
        check("t2_code", 32'(key_bus.key_code), 32'h9);
        check("t2_held", 32'(key_bus.key_held), 32'h1);
        @(posedge clk); #1;
        check("t2_valid_1clk", 32'(key_bus.key_valid), 32'h0);
        tick_n(3);
        check("t2_still_held", 32'(key_bus.key_held), 32'h1);
        pressed[9] = 1'b0;
        tick_n(3);
        check("t2_rel3_held", 32'(key_bus.key_held), 32'h1);
        tick_n(1);
        check("t2_rel4_held", 32'(key_bus.key_held), 32'h0);
        check("t2_next_row", 32'(row_n), 32'h7);
        check("t2_code_kept", 32'(key_bus.key_code), 32'h9);
        check("t2_pulses", 32'(pulse_cnt - p0), 32'h1);

        // 3. Bounce on the third debounce tick, then a stable press
        do_reset();
        p0 = pulse_cnt;
        pressed[9] = 1'b1;
        tick_n(8);
        pressed[9] = 1'b0;
        tick_n(1);
        check("t3_bounce_valid", 32'(key_bus.key_valid), 32'h0);
        check("t3_bounce_row", 32'(row_n), 32'hB);
        check("t3_bounce_held", 32'(key_bus.key_held), 32'h0);
        pressed[9] = 1'b1;
        tick_n(4);
        check("t3_pre_valid", 32'(key_bus.key_valid), 32'h0);
        tick_n(1);
        check("t3_valid", 32'(key_bus.key_valid), 32'h1);
        check("t3_code", 32'(key_bus.key_code), 32'h9);
        @(posedge clk); #1;
        check("t3_pulses", 32'(pulse_cnt - p0), 32'h1);
        pressed = '0;

        // 4. Two columns on row1; a later row3 press is ignored while held
        do_reset();
        p0 = pulse_cnt;
        pressed[4] = 1'b1;
        pressed[7] = 1'b1;
        tick_n(6);
        check("t4_pre_valid", 32'(key_bus.key_valid), 32'h0);
        tick_n(1);
        check("t4_valid", 32'(key_bus.key_valid), 32'h1);
        check("t4_code", 32'(key_bus.key_code), 32'h4);
        pressed[15] = 1'b1;
        tick_n(6);
        check("t4_held", 32'(key_bus.key_held), 32'h1);
        check("t4_row_kept", 32'(row_n), 32'hD);
        check("t4_code_kept", 32'(key_bus.key_code), 32'h4);
        check("t4_pulses", 32'(pulse_cnt - p0), 32'h1);

        // 5. Reset while HELD
        p0 = pulse_cnt;
        do_reset();
        check("t5_held", 32'(key_bus.key_held), 32'h0);
        check("t5_row_n", 32'(row_n), 32'hE);
        check("t5_code", 32'(key_bus.key_code), 32'h0);
        check("t5_valid", 32'(key_bus.key_valid), 32'h0);
        pressed = '0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_pulses", 32'(pulse_cnt - p0), 32'h0);

        // 6. Long hold of key F
        do_reset();
        p0 = pulse_cnt;
        pressed[15] = 1'b1;
        tick_n(10);
        check("t6_pre_valid", 32'(key_bus.key_valid), 32'h0);
        tick_n(1);
        check("t6_valid", 32'(key_bus.key_valid), 32'h1);
        check("t6_code", 32'(key_bus.key_code), 32'hF);
        tick_n(3);
`ifdef KEYPAD_REPEAT_EN
        check("t6_repeat_pulse", 32'(key_bus.key_valid), 32'h1);
`else
        check("t6_repeat_pulse", 32'(key_bus.key_valid), 32'h0);
`endif
        tick_n(7);
        @(posedge clk); #1;
        check("t6_held", 32'(key_bus.key_held), 32'h1);
        check("t6_code_kept", 32'(key_bus.key_code), 32'hF);
`ifdef KEYPAD_REPEAT_EN
        check("t6_pulses", 32'(pulse_cnt - p0), 32'h4);
`else
        check("t6_pulses", 32'(pulse_cnt - p0), 32'h1);
`endif
        pressed = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
